// File: rtl/awb_stats.sv
// awb_stats: gray-world auto-white-balance statistics.
// Accumulates per-channel sums over a frame and latches the frame means at
// frame end. It then runs two sequential 16-step restoring divisions,
// (mean_g<<8)/mean_r and (mean_g<<8)/mean_b, to produce Q4.8 gains.
// Optional build macro AWB_PASSTHRU_EN adds a one-cycle registered copy of the
// input beat on the pixel_out/valid_out/color_out/last_col_out/last_pic_out ports.
module awb_stats #(
    parameter int COLOR_DEPTH   = 8,
    parameter int GAIN_BIT_CNT  = 12,   // must not exceed COLOR_DEPTH+8
    parameter int LOG2_PIX      = 20,
    parameter int COLOR_BIT_CNT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLOR_DEPTH-1:0]   pixel_in,
    input  logic                     valid_in,
    input  logic [COLOR_BIT_CNT-1:0] color_in,
    input  logic                     last_col_in,
    input  logic                     last_pic_in,
    output logic                     ready_in,
    output logic [COLOR_DEPTH-1:0]   mean_r,
    output logic [COLOR_DEPTH-1:0]   mean_g,
    output logic [COLOR_DEPTH-1:0]   mean_b,
    output logic [GAIN_BIT_CNT-1:0]  gain_r,
    output logic [GAIN_BIT_CNT-1:0]  gain_g,
    output logic [GAIN_BIT_CNT-1:0]  gain_b,
    output logic                     stats_valid,
    output logic                     frame_err,
    output logic                     busy
`ifdef AWB_PASSTHRU_EN
    ,
    output logic [COLOR_DEPTH-1:0]   pixel_out,
    output logic                     valid_out,
    output logic [COLOR_BIT_CNT-1:0] color_out,
    output logic                     last_col_out,
    output logic                     last_pic_out
`endif
);

    localparam int SW   = COLOR_DEPTH + LOG2_PIX;   // sum width
    localparam int FRAC = 8;                        // Q4.8 fraction bits
    localparam int QW   = COLOR_DEPTH + FRAC;       // dividend/quotient width = iterations
    localparam int CW   = $clog2(QW);

    localparam logic [COLOR_BIT_CNT-1:0] CLR_RED   = COLOR_BIT_CNT'(0);
    localparam logic [COLOR_BIT_CNT-1:0] CLR_GREEN = COLOR_BIT_CNT'(1);
    localparam logic [COLOR_BIT_CNT-1:0] CLR_BLUE  = COLOR_BIT_CNT'(2);
    localparam logic [LOG2_PIX:0]        TRIP_FULL = {1'b1, {LOG2_PIX{1'b0}}};
    localparam logic [CW-1:0]            DIV_LAST  = CW'(QW - 1);
    localparam logic [GAIN_BIT_CNT-1:0]  GAIN_ONE  = GAIN_BIT_CNT'(1 << FRAC);

    typedef enum logic [1:0] {ACCUM, DIV_R, DIV_B, DONE} state_t;

    state_t state_q, state_d;

    logic [SW-1:0]           sum_r_q, sum_g_q, sum_b_q;
    logic [SW-1:0]           sum_r_d, sum_g_d, sum_b_d;
    logic [LOG2_PIX:0]       trip_q, trip_d;
    logic                    void_q, void_d;
    logic [COLOR_DEPTH-1:0]  mean_r_q, mean_g_q, mean_b_q;
    logic [COLOR_DEPTH-1:0]  mean_r_d, mean_g_d, mean_b_d;
    logic [GAIN_BIT_CNT-1:0] gain_r_q, gain_g_q, gain_b_q, gain_r_tmp_q;
    logic                    frame_err_q;

    // divider: rem_q is the partial remainder, dq_q shifts the dividend out
    // at the top while quotient bits shift in at the bottom
    logic [COLOR_DEPTH-1:0]  rem_q, rem_d;
    logic [QW-1:0]           dq_q, dq_d;
    logic [COLOR_DEPTH-1:0]  dvs_q;
    logic [CW-1:0]           dcnt_q;
    logic [COLOR_DEPTH:0]    rem_shift;
    logic                    rem_ge;

    logic accept, frame_end, div_last;

    assign accept    = valid_in && (state_q == ACCUM);
    assign frame_end = accept && last_pic_in;
    assign div_last  = (dcnt_q == DIV_LAST);

    // Divisor zero and quotients beyond the gain range both clamp to all-ones.
    function automatic logic [GAIN_BIT_CNT-1:0] sat_gain(input logic [QW-1:0] q,
                                                        input logic [COLOR_DEPTH-1:0] dv);
        if (dv == '0 || (q >> GAIN_BIT_CNT) != '0) return '1;
        return q[GAIN_BIT_CNT-1:0];
    endfunction

    // Accumulator next values including the beat accepted this cycle.
    always_comb begin
        sum_r_d = sum_r_q;
        sum_g_d = sum_g_q;
        sum_b_d = sum_b_q;
        trip_d  = trip_q;
        void_d  = void_q;
        if (accept) begin
            if (color_in == CLR_RED)        sum_r_d = sum_r_q + SW'(pixel_in);
            else if (color_in == CLR_GREEN) sum_g_d = sum_g_q + SW'(pixel_in);
            else if (color_in == CLR_BLUE) begin
                sum_b_d = sum_b_q + SW'(pixel_in);
                trip_d  = trip_q + 1'b1;
            end else                        void_d  = 1'b1;
        end
        mean_r_d = sum_r_d[SW-1:LOG2_PIX];
        mean_g_d = sum_g_d[SW-1:LOG2_PIX];
        mean_b_d = sum_b_d[SW-1:LOG2_PIX];
    end

    // One restoring-division step: shift in next dividend bit, subtract if possible.
    always_comb begin
        rem_shift = {rem_q, dq_q[QW-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        rem_d     = rem_ge ? COLOR_DEPTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[COLOR_DEPTH-1:0];
        dq_d      = {dq_q[QW-2:0], rem_ge};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // FSM next state: frame end starts the red division, then blue, then a done beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (frame_end) state_d = DIV_R;
            DIV_R:   if (div_last)  state_d = DIV_B;
            DIV_B:   if (div_last)  state_d = DONE;
            default:                state_d = ACCUM;
        endcase
    end

    // FSM outputs: input stalls and busy flags for the whole post-frame window.
    always_comb begin
        ready_in    = (state_q == ACCUM);
        busy        = (state_q != ACCUM);
        stats_valid = (state_q == DONE);
    end

    // Datapath: accumulate, latch means at frame end, iterate the divider, publish gains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r_q      <= '0;
            sum_g_q      <= '0;
            sum_b_q      <= '0;
            trip_q       <= '0;
            void_q       <= 1'b0;
            mean_r_q     <= '0;
            mean_g_q     <= '0;
            mean_b_q     <= '0;
            gain_r_q     <= '0;
            gain_g_q     <= '0;
            gain_b_q     <= '0;
            gain_r_tmp_q <= '0;
            frame_err_q  <= 1'b0;
            rem_q        <= '0;
            dq_q         <= '0;
            dvs_q        <= '0;
            dcnt_q       <= '0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (frame_end) begin
                        sum_r_q     <= '0;
                        sum_g_q     <= '0;
                        sum_b_q     <= '0;
                        trip_q      <= '0;
                        void_q      <= 1'b0;
                        mean_r_q    <= mean_r_d;
                        mean_g_q    <= mean_g_d;
                        mean_b_q    <= mean_b_d;
                        frame_err_q <= (trip_d != TRIP_FULL) || void_d;
                        rem_q       <= '0;
                        dq_q        <= {mean_g_d, {FRAC{1'b0}}};
                        dvs_q       <= mean_r_d;
                        dcnt_q      <= '0;
                    end else begin
                        sum_r_q <= sum_r_d;
                        sum_g_q <= sum_g_d;
                        sum_b_q <= sum_b_d;
                        trip_q  <= trip_d;
                        void_q  <= void_d;
                    end
                end
                DIV_R: begin
                    rem_q  <= rem_d;
                    dq_q   <= dq_d;
                    dcnt_q <= dcnt_q + 1'b1;
                    if (div_last) begin
                        gain_r_tmp_q <= sat_gain(dq_d, dvs_q);
                        rem_q        <= '0;
                        dq_q         <= {mean_g_q, {FRAC{1'b0}}};
                        dvs_q        <= mean_b_q;
                        dcnt_q       <= '0;
                    end
                end
                DIV_B: begin
                    rem_q  <= rem_d;
                    dq_q   <= dq_d;
                    dcnt_q <= dcnt_q + 1'b1;
                    if (div_last) begin
                        gain_r_q <= gain_r_tmp_q;
                        gain_g_q <= GAIN_ONE;
                        gain_b_q <= sat_gain(dq_d, dvs_q);
                        dcnt_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mean_r    = mean_r_q;
    assign mean_g    = mean_g_q;
    assign mean_b    = mean_b_q;
    assign gain_r    = gain_r_q;
    assign gain_g    = gain_g_q;
    assign gain_b    = gain_b_q;
    assign frame_err = frame_err_q;

`ifdef AWB_PASSTHRU_EN
    // Pass-through: one-cycle registered copy of the input beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_out    <= '0;
            valid_out    <= 1'b0;
            color_out    <= '0;
            last_col_out <= 1'b0;
            last_pic_out <= 1'b0;
        end else begin
            pixel_out    <= pixel_in;
            valid_out    <= valid_in && ready_in;
            color_out    <= color_in;
            last_col_out <= last_col_in;
            last_pic_out <= last_pic_in;
        end
    end
`else
    // Row boundaries carry no meaning for the statistics.
    logic unused_last_col;
    assign unused_last_col = last_col_in;
`endif

endmodule
